// File: rtl/iic_pkg.sv
// iic_pkg: command encoding and state types shared by the I2C burst controller and its bit engine
package iic_pkg;
   localparam logic [5:0] CMD_WR   = 6'b000001;
   localparam logic [5:0] CMD_STA  = 6'b000010;
   localparam logic [5:0] CMD_RD   = 6'b000100;
   localparam logic [5:0] CMD_STO  = 6'b001000;
   localparam logic [5:0] CMD_ACK  = 6'b010000;
   localparam logic [5:0] CMD_NACK = 6'b100000;

   typedef enum logic [2:0] {DEV_W, ADDR_H, ADDR_L, DEV_R, DATA, STOP_ONLY} phase_e;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} ctrl_e;

   function automatic logic has_cmd(input logic [5:0] cmd, input logic [5:0] sel);
      return |(cmd & sel);
   endfunction
endpackage

// File: rtl/iic_bit_shift.sv
// iic_bit_shift: runs one OR-ed command word (START, byte write/read with ack bit, STOP) on SCL/SDA
module iic_bit_shift
   import iic_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] cmd,
   input  logic       go,
   input  logic [7:0] tx_data,
   output logic [7:0] rx_data,
   output logic       trans_done,
   output logic       ack_o,
   output logic       iic_clk,
   inout  wire        iic_sda
);
   typedef enum logic [1:0] {B_IDLE, B_STA, B_BIT, B_STO} bstate_e;

   bstate_e    st_q;
   logic [1:0] qtr_q;
   logic [3:0] bit_q;
   logic [5:0] cmd_q;
   logic [7:0] sh_q;
   logic       scl_q, oe_q;

   assign iic_clk = scl_q;
   assign iic_sda = oe_q ? 1'b0 : 1'bz;

   // quarter-bit sequencer; one shift register serves both transmit (MSB out) and receive (LSB in)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q       <= B_IDLE;
         qtr_q      <= 2'd0;
         bit_q      <= 4'd0;
         cmd_q      <= 6'd0;
         sh_q       <= 8'd0;
         rx_data    <= 8'd0;
         ack_o      <= 1'b0;
         trans_done <= 1'b0;
         scl_q      <= 1'b1;
         oe_q       <= 1'b0;
      end else begin
         trans_done <= 1'b0;
         qtr_q      <= (st_q == B_IDLE) ? 2'd0 : qtr_q + 2'd1;
         case (st_q)
            B_IDLE: if (go) begin
               cmd_q      <= cmd;
               sh_q       <= tx_data;
               bit_q      <= 4'd0;
               st_q       <= has_cmd(cmd, CMD_STA) ? B_STA : has_cmd(cmd, CMD_WR | CMD_RD) ? B_BIT :
                             has_cmd(cmd, CMD_STO) ? B_STO : B_IDLE;
               trans_done <= ~has_cmd(cmd, CMD_STA | CMD_WR | CMD_RD | CMD_STO);
            end
            B_STA: case (qtr_q)
               2'd0: oe_q <= 1'b0;
               2'd1: scl_q <= 1'b1;
               2'd2: oe_q <= 1'b1;
               default: begin
                  scl_q      <= 1'b0;
                  st_q       <= has_cmd(cmd_q, CMD_WR | CMD_RD) ? B_BIT : has_cmd(cmd_q, CMD_STO) ? B_STO : B_IDLE;
                  trans_done <= ~has_cmd(cmd_q, CMD_WR | CMD_RD | CMD_STO);
               end
            endcase
            B_BIT: case (qtr_q)
               2'd0: oe_q <= (bit_q == 4'd8) ? has_cmd(cmd_q, CMD_RD) & has_cmd(cmd_q, CMD_ACK)
                                             : has_cmd(cmd_q, CMD_WR) & ~sh_q[7];
               2'd1: scl_q <= 1'b1;
               2'd2: if (bit_q == 4'd8) begin
                  rx_data <= sh_q;
                  ack_o   <= has_cmd(cmd_q, CMD_WR) & iic_sda;
               end else begin
                  sh_q <= {sh_q[6:0], iic_sda};
               end
               default: begin
                  scl_q <= 1'b0;
                  bit_q <= bit_q + 4'd1;
                  if (bit_q == 4'd8) begin
                     st_q       <= has_cmd(cmd_q, CMD_STO) ? B_STO : B_IDLE;
                     trans_done <= ~has_cmd(cmd_q, CMD_STO);
                  end
               end
            endcase
            default: case (qtr_q)
               2'd0: oe_q <= 1'b1;
               2'd1: scl_q <= 1'b1;
               2'd2: oe_q <= 1'b0;
               default: begin
                  st_q       <= B_IDLE;
                  trans_done <= 1'b1;
               end
            endcase
         endcase
      end
   end
endmodule

// File: rtl/iic_burst_ctrl.sv
// iic_burst_ctrl: sequences device/address/burst bytes of one I2C write or read through iic_bit_shift
module iic_burst_ctrl
   import iic_pkg::*;
#(
   parameter int CNT_W         = 16,
   parameter bit ABORT_ON_NACK = 1'b1
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             w_req,
   input  logic             r_req,
   input  logic [7:0]       device_id,
   input  logic [15:0]      reg_addr,
   input  logic             addr_mode,
   input  logic [CNT_W-1:0] len,
   input  logic [7:0]       wr_data,
   output logic             wr_req_o,
   output logic [7:0]       rd_data,
   output logic             r_valid,
   output logic             busy,
   output logic             done,
   output logic             nack_err,
   output logic             iic_clk,
   inout  wire              iic_sda
);
   ctrl_e            state_q;
   phase_e           phase_q, phase_d;
   logic             rd_q, mode_q, go_q, busy_q, done_q, nack_q, r_valid_q;
   logic [15:0]      addr_q;
   logic [7:0]       id_q, tx_q, tx_d, rd_data_q, rx_data;
   logic [CNT_W-1:0] len_q, cnt_q;
   logic [5:0]       cmd_q, cmd_d;
   logic             trans_done, ack, last, nack_hit, fin;

   iic_bit_shift u_bit (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd        (cmd_q),
      .go         (go_q),
      .tx_data    (tx_q),
      .rx_data    (rx_data),
      .trans_done (trans_done),
      .ack_o      (ack),
      .iic_clk    (iic_clk),
      .iic_sda    (iic_sda)
   );

   assign wr_req_o = (state_q == ISSUE) && (phase_q == DATA) && !rd_q;
   assign rd_data  = rd_data_q;
   assign r_valid  = r_valid_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign nack_err = nack_q;

   // command word for the current phase and the phase that follows a completed byte
   always_comb begin
      last     = cnt_q == len_q - 1'b1;
      nack_hit = ack & has_cmd(cmd_q, CMD_WR);
      fin      = (phase_q == STOP_ONLY) || has_cmd(cmd_q, CMD_STO);
      cmd_d    = CMD_STO;
      tx_d     = 8'h00;
      phase_d  = phase_q;
      case (phase_q)
         DEV_W: begin
            cmd_d   = CMD_STA | CMD_WR;
            tx_d    = id_q & 8'hFE;
            phase_d = mode_q ? ADDR_H : ADDR_L;
         end
         ADDR_H: begin
            cmd_d   = CMD_WR;
            tx_d    = addr_q[15:8];
            phase_d = ADDR_L;
         end
         ADDR_L: begin
            cmd_d   = CMD_WR;
            tx_d    = addr_q[7:0];
            phase_d = rd_q ? DEV_R : DATA;
         end
         DEV_R: begin
            cmd_d   = CMD_STA | CMD_WR;
            tx_d    = id_q | 8'h01;
            phase_d = DATA;
         end
         DATA: begin
            cmd_d = rd_q ? (CMD_RD | (last ? (CMD_NACK | CMD_STO) : CMD_ACK)) : (CMD_WR | (last ? CMD_STO : 6'd0));
            tx_d  = wr_data;
         end
         default: ;
      endcase
      if (nack_hit && ABORT_ON_NACK) phase_d = STOP_ONLY;
   end

   // request acceptance, one-byte-at-a-time issue/wait handshake and completion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         phase_q   <= DEV_W;
         rd_q      <= 1'b0;
         mode_q    <= 1'b0;
         addr_q    <= 16'd0;
         id_q      <= 8'd0;
         len_q     <= '0;
         cnt_q     <= '0;
         go_q      <= 1'b0;
         cmd_q     <= 6'd0;
         tx_q      <= 8'd0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         nack_q    <= 1'b0;
         r_valid_q <= 1'b0;
         rd_data_q <= 8'd0;
      end else begin
         done_q    <= 1'b0;
         r_valid_q <= 1'b0;
         go_q      <= 1'b0;
         case (state_q)
            IDLE: if (w_req || r_req) begin
               rd_q    <= !w_req;
               mode_q  <= addr_mode;
               addr_q  <= reg_addr;
               id_q    <= device_id;
               len_q   <= len;
               cnt_q   <= '0;
               phase_q <= DEV_W;
               busy_q  <= 1'b1;
               nack_q  <= 1'b0;
               state_q <= (len == '0) ? FIN : ISSUE;
            end
            ISSUE: begin
               cmd_q   <= cmd_d;
               tx_q    <= tx_d;
               go_q    <= 1'b1;
               state_q <= WAIT;
            end
            WAIT: if (trans_done) begin
               if (nack_hit) nack_q <= 1'b1;
               if (phase_q == DATA && rd_q) begin
                  rd_data_q <= rx_data;
                  r_valid_q <= 1'b1;
               end
               if (fin) begin
                  state_q <= IDLE;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  state_q <= ISSUE;
                  phase_q <= phase_d;
                  if (phase_q == DATA) cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_iic_burst_ctrl.sv
// tb_iic_burst_ctrl: scoreboard bench with a behavioural I2C slave on the bus
module tb_iic_burst_ctrl;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        w_req = 1'b0, r_req = 1'b0, addr_mode = 1'b0;
   logic [7:0]  device_id = 8'hA1;
   logic [15:0] reg_addr = 16'd0, len = 16'd0;
   logic [7:0]  wr_data = 8'd0, rd_data;
   logic        wr_req_o, r_valid, busy, done, nack_err, iic_clk;
   wire         iic_sda;
   logic        sda_drv = 1'b0;

   pullup (iic_sda);
   assign iic_sda = sda_drv ? 1'b0 : 1'bz;

   int errors = 0, checks = 0;
   int bus_q[$], rd_q[$];
   logic [7:0] wq[$], slv_q[$];
   int nack_at = -1, done_cnt = 0, wr_cnt = 0, scl_edges = 0, rx_idx = 0, bitcnt = 0;
   bit mon_en = 1'b0, active = 1'b0, first = 1'b0, txm = 1'b0, rd_after = 1'b0, mack = 1'b0;
   logic [7:0] sh = 8'd0, tsh = 8'd0;

   always #5 clk = ~clk;

   iic_burst_ctrl #(.CNT_W(16), .ABORT_ON_NACK(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .w_req(w_req), .r_req(r_req), .device_id(device_id),
      .reg_addr(reg_addr), .addr_mode(addr_mode), .len(len), .wr_data(wr_data),
      .wr_req_o(wr_req_o), .rd_data(rd_data), .r_valid(r_valid), .busy(busy), .done(done),
      .nack_err(nack_err), .iic_clk(iic_clk), .iic_sda(iic_sda)
   );

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // bus events: 'h100 START, 'h200 STOP, 'h400/'h401 master ACK/NACK, else byte seen by slave
   task automatic log_ev(input int e);
      check("bus", e, bus_q.size() > 0 ? bus_q.pop_front() : 'hFFF);
   endtask

   task automatic exp_ev(input int e[$]);
      foreach (e[i]) bus_q.push_back(e[i]);
   endtask

   task automatic req(input bit w, input bit r, input bit mode, input int addr, input int n);
      @(negedge clk);
      addr_mode = mode;
      reg_addr  = addr[15:0];
      len       = n[15:0];
      rx_idx    = 0;
      w_req     = w;
      r_req     = r;
      @(negedge clk);
      w_req = 1'b0;
      r_req = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!done && n < 4000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done"}, int'(done), 1);
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (wr_req_o) begin
         wr_cnt++;
         wr_data = wq.size() > 0 ? wq.pop_front() : 8'h00;
      end
   end

   always @(negedge clk) if (r_valid) check("rd_data", rd_data, rd_q.size() > 0 ? rd_q.pop_front() : -1);

   always @(iic_clk) if (mon_en) scl_edges++;

   always @(negedge iic_sda) if (mon_en && iic_clk === 1'b1) begin
      log_ev('h100);
      active = 1'b1; first = 1'b1; bitcnt = 0; txm = 1'b0; rd_after = 1'b0; sda_drv = 1'b0;
   end

   always @(posedge iic_sda) if (mon_en && iic_clk === 1'b1) begin
      log_ev('h200);
      active = 1'b0; bitcnt = 0; txm = 1'b0; sda_drv = 1'b0;
   end

   always @(posedge iic_clk) if (mon_en && active) begin
      if (bitcnt < 8) sh = {sh[6:0], (iic_sda === 1'b0) ? 1'b0 : 1'b1};
      else if (txm) begin
         mack = (iic_sda !== 1'b0);
         log_ev(mack ? 'h401 : 'h400);
      end
      bitcnt++;
   end

   always @(negedge iic_clk) if (mon_en && active) begin
      if (bitcnt == 8) begin
         if (txm) sda_drv = 1'b0;
         else begin
            log_ev(int'(sh));
            sda_drv  = (rx_idx != nack_at);
            rd_after = first && sh[0];
            first    = 1'b0;
            rx_idx++;
         end
      end else if (bitcnt == 9) begin
         bitcnt  = 0;
         sda_drv = 1'b0;
         if (rd_after) begin
            txm = 1'b1;
            rd_after = 1'b0;
         end else if (txm && mack) txm = 1'b0;
         if (txm) tsh = slv_q.size() > 0 ? slv_q.pop_front() : 8'hFF;
      end
      if (txm && bitcnt < 8) sda_drv = !tsh[7 - bitcnt];
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int d0, w0, e0, n;
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_nack", nack_err, 0);
      check("rst_wreq", wr_req_o, 0);
      check("rst_rvalid", r_valid, 0);
      check("rst_rd_data", rd_data, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      mon_en = 1'b1;

      // write, 2-byte address, 3 data bytes
      exp_ev('{'h100, 'hA0, 'h12, 'h34, 'hA5, 'h5A, 'hFF, 'h200});
      wq = '{8'hA5, 8'h5A, 8'hFF};
      d0 = done_cnt; w0 = wr_cnt;
      req(1, 0, 1, 'h1234, 3);
      check("t1_busy", busy, 1);
      wait_done("t1");
      check("t1_busy_end", busy, 0);
      check("t1_wr_pulses", wr_cnt - w0, 3);
      check("t1_done_cnt", done_cnt - d0, 1);
      check("t1_nack", nack_err, 0);
      check("t1_bus_left", bus_q.size(), 0);

      // read, 1-byte address, 2 bytes
      exp_ev('{'h100, 'hA0, 'h42, 'h100, 'hA1, 'h400, 'h401, 'h200});
      slv_q = '{8'h3C, 8'hC3};
      rd_q  = '{8'h3C, 8'hC3};
      req(0, 1, 0, 'h0042, 2);
      wait_done("t2");
      check("t2_rd_last", rd_data, 'hC3);
      check("t2_rd_left", rd_q.size(), 0);
      check("t2_nack", nack_err, 0);
      check("t2_bus_left", bus_q.size(), 0);

      // slave NACKs the device byte
      nack_at = 0;
      exp_ev('{'h100, 'hA0, 'h200});
      wq = '{8'h11, 8'h22};
      d0 = done_cnt; w0 = wr_cnt;
      req(1, 0, 1, 'h1234, 2);
      wait_done("t3");
      check("t3_nack", nack_err, 1);
      check("t3_wr_pulses", wr_cnt - w0, 0);
      check("t3_done_cnt", done_cnt - d0, 1);
      check("t3_bus_left", bus_q.size(), 0);
      nack_at = -1;
      wq.delete();

      // simultaneous requests pick write; a request during busy is dropped
      exp_ev('{'h100, 'hA0, 'h07, 'h77, 'h200});
      wq = '{8'h77};
      d0 = done_cnt; w0 = wr_cnt;
      req(1, 1, 0, 'h0007, 1);
      check("t4_nack_clr", nack_err, 0);
      @(negedge clk); w_req = 1'b1;
      @(negedge clk); w_req = 1'b0;
      wait_done("t4");
      repeat (60) @(negedge clk);
      check("t4_done_cnt", done_cnt - d0, 1);
      check("t4_wr_pulses", wr_cnt - w0, 1);
      check("t4_busy", busy, 0);
      check("t4_bus_left", bus_q.size(), 0);

      // zero-length write
      e0 = scl_edges;
      req(1, 0, 0, 'h0000, 0);
      check("t5_busy1", busy, 1);
      check("t5_done1", done, 0);
      @(negedge clk);
      check("t5_done2", done, 1);
      check("t5_busy2", busy, 0);
      @(negedge clk);
      check("t5_done3", done, 0);
      check("t5_scl", scl_edges - e0, 0);

      // single-byte read
      exp_ev('{'h100, 'hA0, 'h55, 'h100, 'hA1, 'h401, 'h200});
      slv_q = '{8'h99};
      rd_q  = '{8'h99};
      req(0, 1, 0, 'h0055, 1);
      wait_done("t6");
      check("t6_rd", rd_data, 'h99);
      check("t6_bus_left", bus_q.size(), 0);

      // reset in the middle of the data phase
      exp_ev('{'h100, 'hA0, 'h12, 'h01});
      wq = '{8'h01, 8'h02, 8'h03, 8'h04};
      w0 = wr_cnt;
      req(1, 0, 0, 'h0012, 4);
      n = 0;
      while (wr_cnt < w0 + 2 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("t7_wr_seen", wr_cnt - w0, 2);
      #2;
      mon_en  = 1'b0;
      rst_n   = 1'b0;
      sda_drv = 1'b0;
      #1;
      check("t7_busy", busy, 0);
      check("t7_done", done, 0);
      check("t7_wreq", wr_req_o, 0);
      check("t7_rvalid", r_valid, 0);
      check("t7_nack", nack_err, 0);
      check("t7_rd_data", rd_data, 0);
      check("t7_bus_left", bus_q.size(), 0);
      wq.delete();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      active = 1'b0; txm = 1'b0; bitcnt = 0;
      mon_en = 1'b1;
      exp_ev('{'h100, 'hA0, 'hBE, 'hEF, 'hC1, 'hC2, 'h200});
      wq = '{8'hC1, 8'hC2};
      d0 = done_cnt;
      req(1, 0, 1, 'hBEEF, 2);
      wait_done("t8");
      check("t8_done_cnt", done_cnt - d0, 1);
      check("t8_nack", nack_err, 0);
      check("t8_bus_left", bus_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
